// File: rtl/ifetch_queue.sv
// ifetch_queue: MIPS instruction fetch front end.
// Owns the fetch PC, drives the combinational instruction ROM address and
// buffers {pc, word} pairs in a DEPTH-entry prefetch FIFO that decode drains
// through a valid/ready handshake. A redirect flushes the FIFO and restarts
// fetch at the new target.
// Optional build macro: IFETCH_PERF_EN adds the perf_flush_cnt and
// perf_stall_cnt saturating event counters.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [31:0]      inst_pc_plus4,
`ifdef IFETCH_PERF_EN
  output logic [15:0]      perf_flush_cnt,
  output logic [15:0]      perf_stall_cnt,
`endif
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]    fetch_pc;
  logic [31:0]    pc_mem   [DEPTH];
  logic [31:0]    data_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic           push;
  logic           pop;
  logic [31:0]    head_pc;
  logic [31:0]    head_data;
  logic           unused_redirect_lsbs;

  // Target bits [1:0] are architecturally ignored.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ROM address depends on the fetch PC register only.
  assign rom_addr = {fetch_pc[31:2], 2'b00};

  // Handshake and head-of-queue presentation.
  always_comb begin
    inst_valid    = (count != '0);
    pop           = inst_valid & inst_ready & ~redirect_valid;
    push          = ~redirect_valid & ((count < DEPTH_CNT) | pop);
    head_pc       = pc_mem[rd_ptr];
    head_data     = data_mem[rd_ptr];
    inst          = inst_valid ? head_data      : '0;
    inst_pc       = inst_valid ? head_pc        : '0;
    inst_pc_plus4 = inst_valid ? head_pc + 32'd4 : '0;
    occupancy     = count;
  end

  // Fetch PC, pointers and count; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // FIFO storage write; stale entries are harmless since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= rom_data;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] flush_cnt;
  logic [15:0] stall_cnt;

  assign perf_flush_cnt = flush_cnt;
  assign perf_stall_cnt = stall_cnt;

  // Saturating counters for redirect flushes and decode back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (redirect_valid && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
      if (inst_valid && !inst_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end for the MIPS core. Owns the fetch PC and drives the combinational instruction ROM address.
- Captures the returned instruction word together with its PC into a small prefetch FIFO.
- Presents entries to decode through a valid/ready handshake.
- Redirects (branch/jump/jr from downstream) flush the FIFO and restart fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
DEPTH, 4, FIFO entries; power of two, >= 2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
rom_addr  out  32  byte address to instruction ROM (word aligned, [1:0]=00)
rom_data  in  32  instruction word returned combinationally for rom_addr
redirect_valid  in  1  flush FIFO and restart fetch this edge
redirect_pc  in  32  new fetch byte address; bits [1:0] ignored (treated as 00)
inst_valid  out  1  head entry valid
inst_ready  in  1  decode accepts head entry
inst  out  32  head instruction word
inst_pc  out  32  byte address of head instruction
inst_pc_plus4  out  32  inst_pc + 4 (mod 2^32), for jal link / branch base
occupancy  out  PTR_W+1  number of valid FIFO entries

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- rom_addr = {fetch_pc[31:2], 2'b00}. Combinational from the fetch_pc register only; no path from any input.
- On reset: fetch_pc <= RESET_PC; FIFO emptied (rd_ptr = wr_ptr = 0, count = 0). Outputs after the reset edge: inst_valid=0, occupancy=0.
- inst, inst_pc and inst_pc_plus4 come from the head entry. When inst_valid=0 they are driven to 0.
- pop = inst_valid & inst_ready & ~redirect_valid.
- push = ~redirect_valid & (count < DEPTH | pop). Push writes {fetch_pc, rom_data} at wr_ptr; fetch_pc <= fetch_pc + 4.
- Full with simultaneous pop: push and pop both occur; count is unchanged.
- Empty: no bypass. A pushed word becomes visible at the head on the following cycle, so fetch-to-valid latency is 1 cycle.
- Redirect (highest priority, sampled at edge E):
  - FIFO cleared and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop occur at E. A head offered in that cycle is discarded even if inst_ready=1.
  - After E: inst_valid=0. After E+1: inst_valid=1 with inst_pc = redirect target.
- Back-to-back redirects: each redirect restarts fetch; only the last target survives.
- Reset asserted together with redirect: reset wins.
- Wrap-around:
  - fetch_pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
  - inst_pc_plus4 wraps the same way.
  - FIFO pointers wrap modulo DEPTH.
- Steady state with inst_ready held at 1: one instruction per cycle, no bubbles.
- inst_ready low: FIFO fills to DEPTH, then fetch_pc holds and rom_addr stays constant.
- Decode sees instructions in strict program order of fetch_pc; none duplicated or dropped except by a redirect flush.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Defined:
  - Adds output perf_flush_cnt [15:0]: counts edges where redirect_valid=1 and reset=0; saturates at 16'hFFFF; cleared by reset.
  - Adds output perf_stall_cnt [15:0]: counts edges where inst_valid=1 & inst_ready=0; same saturation and clear.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset, then release with inst_ready=1 and ROM holding program at 0x0..0x44 -> rom_addr 0x0, 0x4, 0x8...; first inst_valid one cycle after reset release with inst_pc=0x0, inst=32'h20040003; then one instruction per cycle, inst_pc_plus4=inst_pc+4.
- inst_ready=0 for 10 cycles from reset release -> occupancy climbs 1,2,3,4 then holds; rom_addr frozen at 0x10; raising inst_ready drains 0x0,0x4,0x8,0xC with no gap, and 0x10 follows.
- FIFO full and inst_ready=1 in the same cycle -> occupancy stays 4, the head advances by one, fetch_pc advances by 4.
- redirect_valid=1, redirect_pc=0x0000_000F with occupancy=3 and inst_ready=1 -> no pop counted; next cycle inst_valid=0, occupancy=0, rom_addr=0xC; following cycle inst_pc=0xC, inst=32'h20420000... (ROM word 3); simultaneous reset+redirect -> fetch_pc=RESET_PC.
- Redirect to 0xFFFF_FFFC, inst_ready=1 -> inst_pc 0xFFFF_FFFC with inst_pc_plus4=0x0, then inst_pc 0x0; reset asserted mid-stream with occupancy=2 -> after the edge inst_valid=0, occupancy=0, rom_addr=RESET_PC.
- IFETCH_PERF_EN: 3 redirects and 5 stalled cycles -> perf_flush_cnt=3, perf_stall_cnt=5; force the counter to 16'hFFFE, apply 3 more redirects -> holds 16'hFFFF; reset -> both 0.
